moore_mod_counter: RTL

Parametrised Moore-style up/down modulo counter with a registered control FSM, synchronous load/clear, selectable wrap or saturate mode, and terminal-count flags. It replaces fixed 2-bit free-running sequencers in timing, sequencing and divider paths. All outputs derive only from registered state (Moore): no input-to-output combinational path.

---
 rtl/moore_mod_counter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/moore_mod_counter.sv
// -----------------------------------------------------------------------------
// moore_mod_counter
//
// Parametrised up/down modulo counter driven by a registered control FSM.
// The FSM state (IDLE / UP / DOWN) is taken from en/up at every edge, and the
// count moves according to the state that is already registered. As a result
// a step always lands one edge after en was sampled high. Every output is
// decoded from registered state only, so no input reaches an output through
// combinational logic.
//
// Parameters:
//   WIDTH    - count register width in bits (>= 1)
//   MAX_VAL  - highest count value; the counter runs modulo MAX_VAL+1
//   SATURATE - 0: wrap at the limits, 1: hold at the limits
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   en        in   count enable request
//   up        in   direction request (1 = up, 0 = down), sampled with en
//   clear     in   synchronous clear of the count (highest priority)
//   load      in   synchronous load of load_val, clamped to MAX_VAL
//   load_val  in   value to load
//   count     out  registered count
//   mode      out  FSM state: 00 IDLE, 01 UP, 10 DOWN
//   at_max    out  count == MAX_VAL
//   at_min    out  count == 0
//   wrap      out  one-cycle pulse in the cycle after a wrap step
// -----------------------------------------------------------------------------
module moore_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       mode,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;

    // -------------------------------------------------------------------------
    // State register
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, whatever order the simulator runs the processes.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= ZERO_C;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. The next state depends only on en/up, so the illegal
    // code 2'b11 goes back to a legal state on the very next edge.
    // -------------------------------------------------------------------------
    always_comb begin
        if (!en) begin
            state_d = ST_IDLE;
        end else if (up) begin
            state_d = ST_UP;
        end else begin
            state_d = ST_DOWN;
        end
    end

    // -------------------------------------------------------------------------
    // Count datapath. The limits are compared against MAX_C rather than against
    // natural overflow, so count never shows a value above MAX_VAL.
    // NOTE: each target gets a default at the top of the block so that no path
    // leaves it unassigned. That prevents latch inference.
    // -------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;

        if (clear) begin
            count_d = ZERO_C;
        end else if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
        end else begin
            unique case (state_q)
                ST_UP: begin
                    if (count_q == MAX_C) begin
                        if (!SATURATE) begin
                            count_d = ZERO_C;
                            wrap_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + ONE_C;
                    end
                end
                ST_DOWN: begin
                    if (count_q == ZERO_C) begin
                        if (!SATURATE) begin
                            count_d = MAX_C;
                            wrap_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q - ONE_C;
                    end
                end
                default: begin
                    // IDLE (and the illegal code) hold the count.
                    count_d = count_q;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        count  = count_q;
        mode   = state_q;
        at_max = (count_q == MAX_C);
        at_min = (count_q == ZERO_C);
        wrap   = wrap_q;
    end

endmodule
